// File: rtl/aes128_pkg.sv
// aes128_pkg: shared definitions for the iterative AES-128 core.
//   - op encodings as seen on the 2-bit op port
//   - FSM state enum
//   - round-constant lookup and GF(2^8) column/row helpers
package aes128_pkg;

  localparam logic [1:0] OP_ENC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEXP   = 2'd1,
    ROUND  = 2'd2,
    FINISH = 2'd3
  } fsm_e;

  // Round constant for round number 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column; bits [31:24] hold row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x [4];
    for (int unsigned i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      x[i] = xtime(a[i]);
    end
    return {x[0] ^ x[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ x[1] ^ x[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ x[2] ^ x[3] ^ a[3],
            x[0] ^ a[0] ^ a[1] ^ a[2] ^ x[3]};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2, m4, m8;
    logic [7:0] e [4];
    logic [7:0] b [4];
    logic [7:0] d [4];
    logic [7:0] n [4];
    for (int unsigned i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      m2   = xtime(a[i]);
      m4   = xtime(m2);
      m8   = xtime(m4);
      e[i] = m8 ^ m4 ^ m2;   // x0e
      b[i] = m8 ^ m2 ^ a[i]; // x0b
      d[i] = m8 ^ m4 ^ a[i]; // x0d
      n[i] = m8 ^ a[i];      // x09
    end
    return {e[0] ^ b[1] ^ d[2] ^ n[3],
            n[0] ^ e[1] ^ b[2] ^ d[3],
            d[0] ^ n[1] ^ e[2] ^ b[3],
            b[0] ^ d[1] ^ n[2] ^ e[3]};
  endfunction

  // Byte i sits at [127-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box.
//   in_byte  : byte to substitute
//   inv      : 0 = forward table, 1 = inverse table
//   out_byte : substituted byte
module aes_sbox (
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  // Entry 0 occupies the top byte of each table.
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry i lives at bit 8*(255-i); 255-i is simply ~i for a byte.
  logic [10:0] idx;

  always_comb begin
    idx      = {~in_byte, 3'b000};
    out_byte = inv ? INV[idx +: 8] : FWD[idx +: 8];
  end

endmodule

// File: rtl/aes128_core.sv
// aes128_core: iterative AES-128 encrypt/decrypt engine, one round per clock.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : request pulse, honoured only while idle
//   op         : 00 encrypt, 01 decrypt, 1x reserved (sets err)
//   key, data  : cipher key and input block, byte 0 in the top byte
//   result     : output block, registered at completion
//   ready      : idle and able to accept start
//   done       : sticky completion flag, cleared by the next valid start
//   err        : sticky flag, last start carried a reserved op
module aes128_core import aes128_pkg::*; #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [127:0] key,
  input  logic [127:0] data,
  output logic [127:0] result,
  output logic         ready,
  output logic         done,
  output logic         err
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_core: only NUM_ROUNDS=10 is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic         dec_q, dec_d;
  logic [127:0] result_q, result_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [127:0] sub_blk;
  logic [31:0]  ks_word, ks_rot, sw;
  logic [127:0] rk_fwd, rk_inv;
  logic [127:0] enc_next, dec_next;

  // The four key-schedule S-boxes serve both directions: the forward step
  // substitutes w3, the inverse step substitutes the recovered w3^w2.
  assign ks_word = (dec_q && fsm_q == ROUND) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
  assign ks_rot  = {ks_word[23:0], ks_word[31:24]};

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .in_byte  (blk_q[127-8*i -: 8]),
      .inv      (dec_q),
      .out_byte (sub_blk[127-8*i -: 8])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_byte  (ks_rot[31-8*i -: 8]),
      .inv      (1'b0),
      .out_byte (sw[31-8*i -: 8])
    );
  end

  // Round datapath. SubBytes and ShiftRows commute, so the S-boxes read the
  // state directly and the row shift is applied to their outputs.
  always_comb begin
    logic [31:0]  w0, w1, w2, w3, t, f0, f1, f2;
    logic [127:0] sr, mc, ark, imc;

    w0 = rk_q[127:96];
    w1 = rk_q[95:64];
    w2 = rk_q[63:32];
    w3 = rk_q[31:0];
    t  = sw ^ {rcon(rnd_q), 24'h000000};

    f0     = w0 ^ t;
    f1     = w1 ^ f0;
    f2     = w2 ^ f1;
    rk_fwd = {f0, f1, f2, w3 ^ f2};
    rk_inv = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    sr = shift_rows(sub_blk);
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end
    enc_next = ((rnd_q == LAST_RND) ? sr : mc) ^ rk_fwd;

    ark = inv_shift_rows(sub_blk) ^ rk_inv;
    imc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end
    dec_next = (rnd_q == 4'd1) ? ark : imc;
  end

  always_comb begin
    fsm_d    = fsm_q;
    rnd_d    = rnd_q;
    blk_d    = blk_q;
    rk_d     = rk_q;
    dec_d    = dec_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          if (op == OP_ENC) begin
            blk_d  = data ^ key;
            rk_d   = key;
            rnd_d  = 4'd1;
            dec_d  = 1'b0;
            done_d = 1'b0;
            err_d  = 1'b0;
            fsm_d  = ROUND;
          end else if (op == OP_DEC) begin
            // The block register holds the latched input until the
            // last round key is known.
            blk_d  = data;
            rk_d   = key;
            rnd_d  = 4'd1;
            dec_d  = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
            fsm_d  = KEXP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      KEXP: begin
        rk_d = rk_fwd;
        if (rnd_q == LAST_RND) begin
          blk_d = blk_q ^ rk_fwd;
          fsm_d = ROUND;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ROUND: begin
        if (!dec_q) begin
          rk_d  = rk_fwd;
          blk_d = enc_next;
          if (rnd_q == LAST_RND) fsm_d = FINISH;
          else                   rnd_d = rnd_q + 4'd1;
        end else begin
          rk_d  = rk_inv;
          blk_d = dec_next;
          if (rnd_q == 4'd1) fsm_d = FINISH;
          else               rnd_d = rnd_q - 4'd1;
        end
      end
      FINISH: begin
        result_d = blk_q;
        done_d   = 1'b1;
        rnd_d    = 4'd0;
        fsm_d    = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      rnd_q    <= '0;
      blk_q    <= '0;
      rk_q     <= '0;
      dec_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      rnd_q    <= rnd_d;
      blk_q    <= blk_d;
      rk_q     <= rk_d;
      dec_q    <= dec_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;
  assign ready  = (fsm_q == IDLE);

endmodule
